// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared state encodings for the spike encoder
package encoder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} enc_state_t;

    typedef enum logic [1:0] {CH_IDLE, CH_REQ, CH_REL, CH_DONE} ch_state_t;

endpackage

// File: rtl/encoder_channel.sv
// rtl/encoder_channel.sv - per-pixel ack synchronizer and 4-phase spike handshake FSM
module encoder_channel
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic clear,
    input  logic ack_out,
    output logic req_out,
    output logic idle_or_done
);

    logic      ack_s1_q, ack_s2_q;
    ch_state_t state_q, state_d;
    logic      req_q, req_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            state_q  <= CH_IDLE;
            req_q    <= 1'b0;
        end else begin
            ack_s1_q <= ack_out;
            ack_s2_q <= ack_s1_q;
            state_q  <= state_d;
            req_q    <= req_d;
        end
    end

    // Ack seen in CH_IDLE or CH_DONE has no effect; only clear leaves CH_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_IDLE: if (fire)      state_d = CH_REQ;
            CH_REQ:  if (ack_s2_q)  state_d = CH_REL;
            CH_REL:  if (!ack_s2_q) state_d = CH_DONE;
            CH_DONE: state_d = CH_DONE;
            default: state_d = CH_IDLE;
        endcase
        if (clear) state_d = CH_IDLE;
        req_d = (state_d == CH_REQ);
    end

    assign req_out      = req_q;
    assign idle_or_done = (state_q == CH_IDLE) || (state_q == CH_DONE);

endmodule

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - latency-codes one image into per-pixel spikes, brighter fires earlier
module spike_encoder
    import encoder_pkg::*;
#(
    parameter int w_size      = 8,
    parameter int neurons_in  = 4,
    parameter int step_cycles = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         img_valid,
    output logic                         img_ready,
    input  logic [neurons_in*w_size-1:0] img_data,
    output logic [neurons_in-1:0]        req_out,
    input  logic [neurons_in-1:0]        ack_out,
    output logic                         busy,
    output logic                         done
);

    localparam int                CW        = $clog2(step_cycles + 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(step_cycles - 1);
    localparam logic [w_size-1:0] STEP_LAST = {w_size{1'b1}};

    enc_state_t                   state_q, state_d;
    logic [neurons_in*w_size-1:0] pix_q, pix_d;
    logic [w_size-1:0]            s_q, s_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         done_q, done_d;
    logic                         clear;
    logic [w_size-1:0]            thr;
    logic [neurons_in-1:0]        fire;
    logic [neurons_in-1:0]        idle_or_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (img_valid) begin
                    pix_d   = img_data;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s_q == STEP_LAST) state_d = DRAIN;
                    else                  s_d = s_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (&idle_or_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Threshold falls one code per step; a channel only accepts fire while idle.
    assign thr = STEP_LAST - s_q;

    for (genvar i = 0; i < neurons_in; i++) begin : g_ch
        logic [w_size-1:0] pix;
        assign pix     = pix_q[w_size*i +: w_size];
        assign fire[i] = (state_q == RUN) && (pix != '0) && (pix >= thr);

        encoder_channel u_ch (
            .clk          (clk),
            .rst          (rst),
            .fire         (fire[i]),
            .clear        (clear),
            .ack_out      (ack_out[i]),
            .req_out      (req_out[i]),
            .idle_or_done (idle_or_done[i])
        );
    end

    assign img_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - directed-vector bench for spike_encoder
module tb_spike_encoder;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           img_valid;
    logic           img_ready;
    logic [N*W-1:0] img_data;
    logic [N-1:0]   req_out;
    logic [N-1:0]   ack_out;
    logic           busy;
    logic           done;

    spike_encoder #(.w_size(W), .neurons_in(N), .step_cycles(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .img_data  (img_data),
        .req_out   (req_out),
        .ack_out   (ack_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Layer model: ack follows req three cycles later.
    logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [N-1:0] force_mask = '0;
    logic         slow_mode  = 1'b0;
    logic         slow_ack0  = 1'b0;

    always @(posedge clk) begin
        d1  <= req_out;
        d2  <= d1;
        d3  <= d2;
        cyc <= cyc + 1;
    end

    always_comb begin
        ack_out = d3 | force_mask;
        if (slow_mode) ack_out[0] = slow_ack0 | force_mask[0];
    end

    int           rise_cnt[N];
    longint       rise_cyc[N];
    logic [N-1:0] req_prev      = '0;
    int           done_cnt      = 0;
    longint       done_cyc      = 0;
    logic         ready_at_done = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_out[i] && !req_prev[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                rise_cyc[i] <= cyc;
            end
        end
        req_prev <= req_out;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            done_cyc      <= cyc;
            ready_at_done <= img_ready;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int     base;
    int     rb[N];
    longint e0, e1;

    task automatic snap();
        base = done_cnt;
        rb   = rise_cnt;
    endtask

    task automatic send(input logic [N*W-1:0] data, output longint e);
        img_data  = data;
        img_valid = 1'b1;
        tick();
        e         = cyc;
        img_valid = 1'b0;
        check("capture_busy", busy, 1);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (done_cnt == base && n < max) begin
            tick();
            n++;
        end
        check(tag, done_cnt - base, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        img_valid = 1'b0;
        img_data  = '0;
        rst       = 1'b1;
        #1 rst    = 1'b0;
        repeat (3) tick();
        check("rst_ready", img_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", req_out, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();

        // Pixels {255,128,1,0}
        snap();
        send({8'd0, 8'd1, 8'd128, 8'd255}, e0);
        check("t1_ready_low", img_ready, 0);
        wait_done(1200, "t1_done");
        check("t1_req0_time", rise_cyc[0] - e0, 1);
        check("t1_req1_time", rise_cyc[1] - e0, 127*SC + 1);
        check("t1_req2_time", rise_cyc[2] - e0, 254*SC + 1);
        for (int i = 0; i < 3; i++) check($sformatf("t1_req%0d_once", i), rise_cnt[i] - rb[i], 1);
        check("t1_req3_never", rise_cnt[3] - rb[3], 0);
        check("t1_done_time", done_cyc - e0, 1030);
        check("t1_ready_at_done", ready_at_done, 1);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_idle_busy", busy, 0);

        // Equal pixels fire together
        snap();
        send({4{8'd200}}, e0);
        wait_done(1200, "t2_done");
        for (int i = 0; i < N; i++) begin
            check($sformatf("t2_req%0d_time", i), rise_cyc[i] - e0, 55*SC + 1);
            check($sformatf("t2_req%0d_once", i), rise_cnt[i] - rb[i], 1);
        end
        check("t2_done_time", done_cyc - e0, 1025);

        // Slow ack on channel 0 holds the image in DRAIN
        slow_mode = 1'b1;
        slow_ack0 = 1'b0;
        snap();
        send({24'd0, 8'd255}, e0);
        repeat (1100) tick();
        check("t3_busy_drain", busy, 1);
        check("t3_no_done", done_cnt - base, 0);
        check("t3_req0_held", req_out[0], 1);
        repeat (900) tick();
        slow_ack0 = 1'b1;
        for (int n = 0; n < 20 && req_out[0]; n++) tick();
        check("t3_req0_release", req_out[0], 0);
        repeat (5) tick();
        check("t3_no_done_rel", done_cnt - base, 0);
        slow_ack0 = 1'b0;
        wait_done(20, "t3_done");
        check("t3_req0_once", rise_cnt[0] - rb[0], 1);
        slow_mode = 1'b0;
        tick();

        // img_valid held with changing data: no recapture until done
        snap();
        img_data  = {8'd0, 8'd100, 8'd250, 8'd10};
        img_valid = 1'b1;
        tick();
        e0       = cyc;
        img_data = $urandom;
        for (int n = 0; n < 1200; n++) begin
            tick();
            if (done_cnt != base) break;
            img_data = $urandom;
        end
        check("t4_done", done_cnt - base, 1);
        check("t4_req0_time", rise_cyc[0] - e0, 245*SC + 1);
        check("t4_req1_time", rise_cyc[1] - e0, 5*SC + 1);
        check("t4_req2_time", rise_cyc[2] - e0, 155*SC + 1);
        check("t4_req3_never", rise_cnt[3] - rb[3], 0);
        check("t4_done_time", done_cyc - e0, 1025);
        snap();
        img_data = {24'd0, 8'd255};
        tick();
        e1        = cyc;
        img_valid = 1'b0;
        check("t4_recapture_time", e1 - done_cyc, 1);
        check("t4_second_busy", busy, 1);
        wait_done(1200, "t4b_done");
        check("t4b_req0_time", rise_cyc[0] - e1, 1);
        check("t4b_req1_none", rise_cnt[1] - rb[1], 0);

        // Reset mid-RUN while req1 is high
        snap();
        send({16'd0, 8'd200, 8'd0}, e0);
        for (int n = 0; n < 300 && !req_out[1]; n++) tick();
        check("t5_req1_seen", req_out[1], 1);
        rst = 1'b0;
        #1;
        check("t5_rst_req", req_out, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", img_ready, 1);
        tick();
        rst = 1'b1;
        tick();
        check("t5_no_done", done_cnt - base, 0);
        snap();
        send({8'd128, 24'd0}, e0);
        wait_done(1200, "t5b_done");
        check("t5b_req3_time", rise_cyc[3] - e0, 127*SC + 1);
        check("t5b_req3_once", rise_cnt[3] - rb[3], 1);

        // Spurious acks on idle/done channels
        force_mask = 4'b1000;
        repeat (10) tick();
        check("t6_idle_req", req_out, 0);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_ready", img_ready, 1);
        snap();
        send({24'd0, 8'd255}, e0);
        repeat (50) tick();
        force_mask = 4'b1001;
        repeat (20) tick();
        check("t6_done_req", req_out, 0);
        force_mask = 4'b1000;
        wait_done(1200, "t6_done");
        check("t6_req0_once", rise_cnt[0] - rb[0], 1);
        check("t6_req3_never", rise_cnt[3] - rb[3], 0);
        check("t6_done_time", done_cyc - e0, 1025);
        force_mask = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
